// File: rtl/image_window_gen_if.sv
// Pixel-in / window-out stream bundle for the 3x3 window generator.
// slave is the generator's view; master is the producer/consumer side around it.
interface image_window_gen_if;
  logic [7:0]            pixel_in;
  logic                  pixel_sof;
  logic                  pixel_valid;
  logic                  pixel_ready;
  logic [0:2][0:2][7:0]  window_data;
  logic                  window_valid;
  logic                  window_ready;
  logic                  frame_done;

  modport master (
    output pixel_in,
    output pixel_sof,
    output pixel_valid,
    input  pixel_ready,
    input  window_data,
    input  window_valid,
    output window_ready,
    input  frame_done
  );

  modport slave (
    input  pixel_in,
    input  pixel_sof,
    input  pixel_valid,
    output pixel_ready,
    output window_data,
    output window_valid,
    input  window_ready,
    output frame_done
  );
endinterface

// File: rtl/image_window_gen.sv
// Streaming 3x3 window generator: raster pixels in, one window per interior pixel out.
// Two line buffers hold the previous two rows; no border padding is produced.
module image_window_gen #(
  parameter int unsigned IMG_WIDTH  = 8,
  parameter int unsigned IMG_HEIGHT = 8
) (
  input logic               clk,
  input logic               rst_n,
  image_window_gen_if.slave stream_io
);

  localparam int unsigned ColW = $clog2(IMG_WIDTH);
  localparam int unsigned RowW = $clog2(IMG_HEIGHT);
  localparam logic [ColW-1:0] LastCol = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0] LastRow = RowW'(IMG_HEIGHT - 1);

  logic [ColW-1:0] col_q, col_d, eff_col;
  logic [RowW-1:0] row_q, row_d, eff_row;

  logic [7:0] lb0_q [IMG_WIDTH];
  logic [7:0] lb1_q [IMG_WIDTH];
  logic [7:0] lb0_rd, lb1_rd;

  logic [0:2][0:2][7:0] win_q, win_d;
  logic                 win_valid_q, win_valid_d;
  logic                 frame_done_q, frame_done_d;

  logic pixel_ready;
  logic accept;
  logic last_col, last_row, interior;

  // A pending window blocks input unless it is being consumed on this edge.
  assign pixel_ready = !win_valid_q || stream_io.window_ready;
  assign accept      = stream_io.pixel_valid && pixel_ready;

  always_comb begin
    eff_col  = stream_io.pixel_sof ? '0 : col_q;
    eff_row  = stream_io.pixel_sof ? '0 : row_q;
    lb0_rd   = lb0_q[eff_col];
    lb1_rd   = lb1_q[eff_col];
    last_col = (eff_col == LastCol);
    last_row = (eff_row == LastRow);
    interior = (eff_row >= RowW'(2)) && (eff_col >= ColW'(2));
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    win_valid_d  = win_valid_q;
    frame_done_d = 1'b0;

    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = stream_io.pixel_in;

      if (last_col) begin
        col_d = '0;
        if (last_row) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = eff_row + RowW'(1);
        end
      end else begin
        col_d = eff_col + ColW'(1);
        row_d = eff_row;
      end
    end

    // A new window replaces a consumed one on the same edge for full throughput.
    if (accept && interior) begin
      win_valid_d = 1'b1;
    end else if (stream_io.window_ready) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffers are overwritten before they are read in a new frame, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[eff_col] <= lb0_rd;
      lb0_q[eff_col] <= stream_io.pixel_in;
    end
  end

  assign stream_io.pixel_ready  = pixel_ready;
  assign stream_io.window_data  = win_q;
  assign stream_io.window_valid = win_valid_q;
  assign stream_io.frame_done   = frame_done_q;

  stall_holds_window: assert property (@(posedge clk) disable iff (!rst_n)
    win_valid_q && !stream_io.window_ready |=> win_valid_q && $stable(win_q));

  frame_done_single: assert property (@(posedge clk) disable iff (!rst_n)
    frame_done_q |=> !frame_done_q);

endmodule
